// File: rtl/miner_pkg.sv
// rtl/miner_pkg.sv - shared widths and search FSM state type for the nonce miner
package miner_pkg;

   localparam int SHA_MSG_BITS   = 447;
   localparam int SHA_LEN_BITS   = 64;
   localparam int HASH_BITS      = 256;
   localparam int NONCE_BITS_DEF = 32;
   localparam int PREFIX_BITS    = SHA_MSG_BITS - NONCE_BITS_DEF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_BEGIN,
      S_WAIT,
      S_CHECK,
      S_FOUND
   } search_state_t;

endpackage

// File: rtl/nonce_search_ctrl_if.sv
// rtl/nonce_search_ctrl_if.sv - begin/complete handshake between search controller and SHA block
interface nonce_search_ctrl_if;
   import miner_pkg::*;

   logic [SHA_MSG_BITS-1:0] sha_msg;
   logic [SHA_LEN_BITS-1:0] sha_length;
   logic                    sha_begin;
   logic                    sha_complete;
   logic [HASH_BITS-1:0]    sha_hash;

   modport master (
      output sha_msg,
      output sha_length,
      output sha_begin,
      input  sha_complete,
      input  sha_hash
   );

   modport slave (
      input  sha_msg,
      input  sha_length,
      input  sha_begin,
      output sha_complete,
      output sha_hash
   );

endinterface

// File: rtl/hash_target_cmp.sv
// rtl/hash_target_cmp.sv - combinational unsigned hash <= target check
module hash_target_cmp
   import miner_pkg::*;
(
   input  logic [HASH_BITS-1:0] i_hash,
   input  logic [HASH_BITS-1:0] i_target,
   output logic                 o_hit
);

   assign o_hit = (i_hash <= i_target);

endmodule

// File: rtl/nonce_search_ctrl.sv
// rtl/nonce_search_ctrl.sv - steps a nonce through the SHA block until hash <= target
module nonce_search_ctrl
   import miner_pkg::*;
#(
   parameter int NONCE_BITS  = 32,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                                clk,
   input  logic                                n_rst,
   input  logic                                start,
   input  logic                                stop,
   input  logic [SHA_MSG_BITS-NONCE_BITS-1:0]  header_prefix,
   input  logic [SHA_LEN_BITS-1:0]             msg_length,
   input  logic [HASH_BITS-1:0]                target,
   input  logic [NONCE_BITS-1:0]               nonce_start,
   input  logic [NONCE_BITS-1:0]               nonce_end,
   output logic                                busy,
   output logic                                found,
   output logic                                exhausted,
   output logic                                timeout_err,
   output logic [NONCE_BITS-1:0]               nonce_out,
   output logic [HASH_BITS-1:0]                hash_out,
   nonce_search_ctrl_if.master                 sha
);

   localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

   search_state_t           r_state;
   logic [NONCE_BITS-1:0]   r_nonce;
   logic [TMO_W-1:0]        r_tmo;
   logic                    r_cmp_q;
   logic                    r_stop_pend;
   logic [SHA_MSG_BITS-1:0] r_sha_msg;
   logic [SHA_LEN_BITS-1:0] r_sha_len;
   logic                    r_sha_begin;
   logic                    r_busy;
   logic                    r_found;
   logic                    r_exhausted;
   logic                    r_timeout_err;
   logic [NONCE_BITS-1:0]   r_nonce_out;
   logic [HASH_BITS-1:0]    r_hash_out;

   logic                    w_hit;
   logic                    w_done_edge;
   logic                    w_stop_seen;
   logic                    w_last;
   logic [NONCE_BITS-1:0]   w_nonce_next;

   hash_target_cmp u_cmp (
      .i_hash   (sha.sha_hash),
      .i_target (target),
      .o_hit    (w_hit)
   );

   // r_cmp_q keeps tracking complete through BEGIN, so a level still high
   // from the previous hash reads as "no edge" until it drops and rises again.
   assign w_done_edge  = sha.sha_complete & ~r_cmp_q;
   assign w_stop_seen  = r_stop_pend | stop;
   assign w_last       = (r_nonce == nonce_end);
   assign w_nonce_next = r_nonce + NONCE_BITS'(1);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state       <= S_IDLE;
         r_nonce       <= '0;
         r_tmo         <= '0;
         r_cmp_q       <= 1'b0;
         r_stop_pend   <= 1'b0;
         r_sha_msg     <= '0;
         r_sha_len     <= '0;
         r_sha_begin   <= 1'b0;
         r_busy        <= 1'b0;
         r_found       <= 1'b0;
         r_exhausted   <= 1'b0;
         r_timeout_err <= 1'b0;
         r_nonce_out   <= '0;
         r_hash_out    <= '0;
      end else begin
         r_cmp_q     <= sha.sha_complete;
         r_sha_begin <= 1'b0;
         if (stop && (r_state != S_IDLE)) begin
            r_stop_pend <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               r_stop_pend <= 1'b0;
               if (start) begin
                  r_busy  <= 1'b1;
                  r_state <= S_LOAD;
               end
            end

            S_LOAD: begin
               r_stop_pend   <= 1'b0;
               r_nonce       <= nonce_start;
               r_sha_msg     <= {header_prefix, nonce_start};
               r_sha_len     <= msg_length;
               r_found       <= 1'b0;
               r_exhausted   <= 1'b0;
               r_timeout_err <= 1'b0;
               r_sha_begin   <= 1'b1;
               r_state       <= S_BEGIN;
            end

            S_BEGIN: begin
               r_tmo   <= '0;
               r_state <= S_WAIT;
            end

            S_WAIT: begin
               if (w_done_edge) begin
                  r_state <= S_CHECK;
               end else if (r_tmo == TMO_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_busy        <= 1'b0;
                  r_state       <= S_IDLE;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end

            // A hit outranks both the end of range and a pending stop.
            S_CHECK: begin
               r_hash_out  <= sha.sha_hash;
               r_nonce_out <= r_nonce;
               if (w_hit) begin
                  r_found <= 1'b1;
                  r_state <= S_FOUND;
               end else if (w_last) begin
                  r_exhausted <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end else if (w_stop_seen) begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_nonce                   <= w_nonce_next;
                  r_sha_msg[NONCE_BITS-1:0] <= w_nonce_next;
                  r_sha_begin               <= 1'b1;
                  r_state                   <= S_BEGIN;
               end
            end

            S_FOUND: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign sha.sha_msg    = r_sha_msg;
   assign sha.sha_length = r_sha_len;
   assign sha.sha_begin  = r_sha_begin;
   assign busy           = r_busy;
   assign found          = r_found;
   assign exhausted      = r_exhausted;
   assign timeout_err    = r_timeout_err;
   assign nonce_out      = r_nonce_out;
   assign hash_out       = r_hash_out;

endmodule
